// File: rtl/acc_ctrl_if.sv
// Handshake bundle between requesters and the accumulator write controller.
// The slave modport is the controller's view; master is the requester side.
interface acc_ctrl_if;
   logic [1:0] req;
   logic [3:0] data0;
   logic [3:0] data1;
   logic       stall;
   logic       sync;
   logic [3:0] acci;
   logic       we;
   logic [1:0] gnt;
   logic [1:0] ack;
   logic       busy;
   logic [7:0] cnt;

   modport slave (
      input  req, data0, data1, stall,
      output sync, acci, we, gnt, ack, busy, cnt
   );

   modport master (
      output req, data0, data1, stall,
      input  sync, acci, we, gnt, ack, busy, cnt
   );
endinterface

// File: rtl/acc_ctrl.sv
// Two-requester accumulator write controller: grant, capture strobe, stallable commit.
// Define ACC_CTRL_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module acc_ctrl (
   input logic       clk,
   input logic       rst,
   acc_ctrl_if.slave bus
);
   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] CAP  = 2'b01;
   localparam logic [1:0] WB   = 2'b10;

   logic [1:0] state_r;
   logic [1:0] gnt_r;
   logic [3:0] acci_r;
   logic       sync_r;
   logic       we_r;
   logic [1:0] ack_r;
   logic [7:0] cnt_r;
   logic       win_s;
   logic [3:0] win_data_s;

`ifdef ACC_CTRL_RR_EN
   logic       last_r;

   // Winner selection: on a tie the requester not granted last wins
   always_comb begin
      win_s = 1'b0;
      if (bus.req == 2'b11) begin
         win_s = ~last_r;
      end else begin
         win_s = ~bus.req[0];
      end
   end

   // Round-robin pointer: remembers the most recent grant
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_r <= 1'b1;
      end else if ((state_r == IDLE) && (bus.req != 2'b00)) begin
         last_r <= win_s;
      end else begin
         last_r <= last_r;
      end
   end
`else
   // Winner selection: fixed priority to requester 0
   always_comb begin
      win_s = 1'b0;
      if (bus.req[0]) begin
         win_s = 1'b0;
      end else begin
         win_s = 1'b1;
      end
   end
`endif

   // Winner data mux
   always_comb begin
      win_data_s = 4'h0;
      if (win_s) begin
         win_data_s = bus.data1;
      end else begin
         win_data_s = bus.data0;
      end
   end

   // Transaction FSM; stall is sampled on the edge that would open the commit cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
         gnt_r   <= 2'b00;
         acci_r  <= 4'h0;
         sync_r  <= 1'b0;
         we_r    <= 1'b0;
         ack_r   <= 2'b00;
         cnt_r   <= 8'h00;
      end else begin
         case (state_r)
            IDLE: begin
               we_r  <= 1'b0;
               ack_r <= 2'b00;
               if (bus.req != 2'b00) begin
                  state_r <= CAP;
                  gnt_r   <= win_s ? 2'b10 : 2'b01;
                  acci_r  <= win_data_s;
                  sync_r  <= 1'b1;
               end else begin
                  state_r <= IDLE;
                  sync_r  <= 1'b0;
               end
            end
            CAP: begin
               state_r <= WB;
               sync_r  <= 1'b0;
               if (!bus.stall) begin
                  we_r  <= 1'b1;
                  ack_r <= gnt_r;
               end else begin
                  we_r  <= 1'b0;
                  ack_r <= 2'b00;
               end
            end
            WB: begin
               sync_r <= 1'b0;
               if (we_r) begin
                  state_r <= IDLE;
                  gnt_r   <= 2'b00;
                  we_r    <= 1'b0;
                  ack_r   <= 2'b00;
                  cnt_r   <= cnt_r + 8'd1;
               end else if (!bus.stall) begin
                  we_r  <= 1'b1;
                  ack_r <= gnt_r;
               end else begin
                  we_r  <= 1'b0;
                  ack_r <= 2'b00;
               end
            end
            default: begin
               state_r <= IDLE;
               gnt_r   <= 2'b00;
               sync_r  <= 1'b0;
               we_r    <= 1'b0;
               ack_r   <= 2'b00;
            end
         endcase
      end
   end

   assign bus.sync = sync_r;
   assign bus.acci = acci_r;
   assign bus.we   = we_r;
   assign bus.gnt  = gnt_r;
   assign bus.ack  = ack_r;
   assign bus.busy = (state_r != IDLE);
   assign bus.cnt  = cnt_r;
endmodule

// File: doc/acc_ctrl.md
ACC_CTRL -- requirements
Module: acc_ctrl

Interface
REQ-001 SHALL have: clk  input  1  single clock, all state on rising edge.
REQ-002 SHALL have: rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-003 SHALL have: req  input  2  per-requester write request; bit i = requester i.
REQ-004 SHALL have: data0  input  4  requester 0 write value.
REQ-005 SHALL have: data1  input  4  requester 1 write value.
REQ-006 SHALL have: stall  input  1  holds the commit phase while 1.
REQ-007 SHALL have: sync  output  1  capture strobe to accumulator staging register.
REQ-008 SHALL have: acci  output  4  value driven to accumulator input.
REQ-009 SHALL have: we  output  1  commit strobe, staging to accumulator output.
REQ-010 SHALL have: gnt  output  2  one-hot owner of current transaction, 0 when idle.
REQ-011 SHALL have: ack  output  2  one-cycle completion pulse to the granted requester.
REQ-012 SHALL have: busy  output  1  1 whenever state is not IDLE.
REQ-013 SHALL have: cnt  output  8  count of completed commits.

Function
REQ-014 All outputs SHALL be registered; no combinational input-to-output path.
REQ-015 FSM SHALL have states IDLE, CAP, WB only; any illegal encoding SHALL return to IDLE next edge.
REQ-016 IDLE: if req != 0 at edge N, SHALL latch winner into gnt, winner data into acci, enter CAP; else stay IDLE.
REQ-017 CAP: sync SHALL be 1 for exactly cycle N+1; next edge SHALL enter WB unconditionally.
REQ-018 WB with stall=0: we=1 and ack[winner]=1 for exactly one cycle; next edge SHALL enter IDLE, clear gnt, increment cnt.
REQ-019 WB with stall=1: we=0, ack=0, SHALL stay WB; commit occurs in first cycle stall=0.
REQ-020 Minimum latency req-to-ack SHALL be 2 cycles; back-to-back transactions SHALL be separated by one IDLE cycle (one commit per 3 cycles max).
REQ-021 acci SHALL hold the latched value from CAP through WB; later data0/data1 changes SHALL be ignored until next IDLE grant.
REQ-022 Requester dropping req after grant SHALL NOT abort the transaction; it completes and acks.
REQ-023 A requester SHALL keep req high until its ack; req still high in the IDLE cycle after ack is a new request.
REQ-024 sync and we SHALL never be 1 in the same cycle; at most one ack bit SHALL be 1.
REQ-025 cnt SHALL wrap 255 -> 0 without flag.
REQ-026 stall SHALL have no effect in IDLE or CAP.

Reset
REQ-027 rst=0 SHALL immediately force state IDLE, sync=0, we=0, acci=0, gnt=0, ack=0, busy=0, cnt=0, arbitration pointer to favour requester 0.
REQ-028 Reset asserted mid-transaction SHALL abort it with no ack and no cnt increment; first grant possible at first edge after release.

Configuration
REQ-029 Macro ACC_CTRL_RR_EN defined: round-robin; with both req bits set, winner SHALL be the requester not granted last; pointer updates on each grant.
REQ-030 Macro ACC_CTRL_RR_EN undefined: fixed priority; requester 0 SHALL always win when both request; no pointer state.

Verification
REQ-031 Reset release, req=01, data0=4'hA, stall=0 -> gnt=01 cycle 1, sync=1/acci=A cycle 1, we=1/ack=01 cycle 2, cnt=1.
REQ-032 req=11 held continuously, data0=3, data1=C, RR on -> acks alternate 01,10,01,10 every 3 cycles, acci 3,C,3,C; RR off -> ack always 01.
REQ-033 req=10, data1=5, stall=1 for 4 cycles from WB -> we/ack stay 0 four cycles, then we=1/ack=10 with acci=5; cnt+1 only once.
REQ-034 Grant requester 0 with data0=7, then change data0 to 2 and drop req during CAP -> commit still acci=7, ack=01.
REQ-035 rst=0 asserted in WB with stall=1 -> all outputs 0 immediately, no ack; 256 completed commits from reset -> cnt=0.
